// File: rtl/neo_z80_pkg.sv
// Shared constants and types for the NEO-D0 Z80-side controller:
// I/O port codes, bank reset values, memory window bases and the I/O FSM states.
package neo_z80_pkg;

  localparam logic [4:0] PORT_CMD       = 5'h00;
  localparam logic [4:0] PORT_BANK      = 5'h08;
  localparam logic [4:0] PORT_BANK_MASK = 5'h1C;
  localparam logic [4:0] PORT_NMI_EN    = 5'h08;
  localparam logic [4:0] PORT_NMI_DIS   = 5'h18;
  localparam logic [4:0] PORT_REPLY     = 5'h0C;

  // Reset banks reproduce a linear mapping of the banked windows.
  localparam logic [7:0] BANK0_RST = 8'h1E;
  localparam logic [7:0] BANK1_RST = 8'h0E;
  localparam logic [7:0] BANK2_RST = 8'h06;
  localparam logic [7:0] BANK3_RST = 8'h02;

  localparam logic [15:0] WIN_B3_BASE   = 16'h8000;
  localparam logic [15:0] WIN_B2_BASE   = 16'hC000;
  localparam logic [15:0] WIN_B1_BASE   = 16'hE000;
  localparam logic [15:0] WIN_B0_BASE   = 16'hF000;
  localparam logic [15:0] WIN_ZRAM_BASE = 16'hF800;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr
  } io_state_e;

endpackage

// File: rtl/neo_z80_ctrl_bankmap.sv
// Combinational Z80 memory decode: fixed ROM, four banked ROM windows and work RAM.
module neo_z80_bankmap
  import neo_z80_pkg::*;
#(
  parameter int unsigned MA_W   = 22,
  parameter int unsigned BANK_W = 8
) (
  input  logic [15:0]             sda_i,
  input  logic                    nmreq_i,
  input  logic [3:0][BANK_W-1:0]  banks_i,
  output logic [MA_W-1:0]         ma_o,
  output logic                    nsdrom_o,
  output logic                    nzram_o
);

  localparam int unsigned WideW = BANK_W + 15;

  logic [WideW-1:0] ma_wide;
  logic             rom_hit;
  logic             ram_hit;

  always_comb begin
    ma_wide = '0;
    rom_hit = 1'b0;
    ram_hit = 1'b0;
    if (sda_i >= WIN_ZRAM_BASE) begin
      ram_hit = 1'b1;
    end else if (sda_i >= WIN_B0_BASE) begin
      ma_wide = WideW'({banks_i[0], sda_i[10:0]});
      rom_hit = 1'b1;
    end else if (sda_i >= WIN_B1_BASE) begin
      ma_wide = WideW'({banks_i[1], sda_i[11:0]});
      rom_hit = 1'b1;
    end else if (sda_i >= WIN_B2_BASE) begin
      ma_wide = WideW'({banks_i[2], sda_i[12:0]});
      rom_hit = 1'b1;
    end else if (sda_i >= WIN_B3_BASE) begin
      ma_wide = WideW'({banks_i[3], sda_i[13:0]});
      rom_hit = 1'b1;
    end else begin
      ma_wide = WideW'(sda_i[14:0]);
      rom_hit = 1'b1;
    end
  end

  assign ma_o     = MA_W'(ma_wide);
  assign nsdrom_o = ~(rom_hit & ~nmreq_i);
  assign nzram_o  = ~(ram_hit & ~nmreq_i);

endmodule

// File: rtl/neo_z80_ctrl.sv
// NEO-D0 sound-side controller: 68k<->Z80 latches, Z80 NMI generation,
// Z80 I/O port decode and M1 ROM bank windows.
module neo_z80_ctrl
  import neo_z80_pkg::*;
#(
  parameter int unsigned MA_W   = 22,
  parameter int unsigned BANK_W = 8
) (
  input  logic            CLK_24M,
  input  logic            RESET,
  input  logic            nSDW,
  input  logic [7:0]      M68K_DATA_U,
  output logic [7:0]      SOUND_REPLY,
  input  logic [15:0]     SDA,
  input  logic [7:0]      SDD_IN,
  output logic [7:0]      SDD_OUT,
  output logic            SDD_OE,
  input  logic            nIORQ,
  input  logic            nMREQ,
  input  logic            nRD,
  input  logic            nWR,
  output logic            nZ80NMI,
  output logic [MA_W-1:0] MA,
  output logic            nSDROM,
  output logic            nZRAM,
  output logic            NMI_EN
);

  io_state_e                state_q, state_d;
  logic                     sdw_prev_q;
  logic [7:0]               cmd_q, cmd_d;
  logic [7:0]               reply_q, reply_d;
  logic                     pending_q, pending_d;
  logic                     nmi_en_q, nmi_en_d;
  logic                     nmi_n_q, nmi_n_d;
  logic [3:0][BANK_W-1:0]   banks_q, banks_d;

  logic       sdw_fall;
  logic       io_rd;
  logic       io_wr;
  logic       do_rd;
  logic       do_wr;
  logic [4:0] port;

  assign sdw_fall = sdw_prev_q & ~nSDW;
  assign io_rd    = ~nIORQ & ~nRD;
  assign io_wr    = ~nIORQ & ~nWR;
  assign port     = SDA[4:0];

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    reply_d   = reply_q;
    pending_d = pending_q;
    nmi_en_d  = nmi_en_q;
    banks_d   = banks_q;
    do_rd     = 1'b0;
    do_wr     = 1'b0;

    // Act only on the IDLE exit so a long strobe performs its action once.
    unique case (state_q)
      StIdle: begin
        if (io_rd) begin
          state_d = StRd;
          do_rd   = 1'b1;
        end else if (io_wr) begin
          state_d = StWr;
          do_wr   = 1'b1;
        end
      end
      StRd, StWr: begin
        if (nIORQ) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (do_rd) begin
      if (port == PORT_CMD) pending_d = 1'b0;
      if ((port & PORT_BANK_MASK) == PORT_BANK) banks_d[SDA[1:0]] = BANK_W'(SDA[15:8]);
    end

    if (do_wr) begin
      case (port)
        PORT_CMD:     cmd_d    = 8'h00;
        PORT_NMI_EN:  nmi_en_d = 1'b1;
        PORT_NMI_DIS: nmi_en_d = 1'b0;
        PORT_REPLY:   reply_d  = SDD_IN;
        default:      ;
      endcase
    end

    // A new 68k command takes priority over a same-cycle Z80 acknowledge.
    if (sdw_fall) begin
      cmd_d     = M68K_DATA_U;
      pending_d = 1'b1;
    end

    nmi_n_d = ~(pending_q & nmi_en_q);
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state_q    <= StIdle;
      sdw_prev_q <= 1'b1;
      cmd_q      <= 8'h00;
      reply_q    <= 8'h00;
      pending_q  <= 1'b0;
      nmi_en_q   <= 1'b0;
      nmi_n_q    <= 1'b1;
      banks_q[0] <= BANK_W'(BANK0_RST);
      banks_q[1] <= BANK_W'(BANK1_RST);
      banks_q[2] <= BANK_W'(BANK2_RST);
      banks_q[3] <= BANK_W'(BANK3_RST);
    end else begin
      state_q    <= state_d;
      sdw_prev_q <= nSDW;
      cmd_q      <= cmd_d;
      reply_q    <= reply_d;
      pending_q  <= pending_d;
      nmi_en_q   <= nmi_en_d;
      nmi_n_q    <= nmi_n_d;
      banks_q    <= banks_d;
    end
  end

  assign SOUND_REPLY = reply_q;
  assign SDD_OUT     = cmd_q;
  assign SDD_OE      = ~nIORQ & ~nRD & (port == PORT_CMD);
  assign nZ80NMI     = nmi_n_q;
  assign NMI_EN      = nmi_en_q;

  neo_z80_bankmap #(
    .MA_W   (MA_W),
    .BANK_W (BANK_W)
  ) u_bankmap (
    .sda_i    (SDA),
    .nmreq_i  (nMREQ),
    .banks_i  (banks_q),
    .ma_o     (MA),
    .nsdrom_o (nSDROM),
    .nzram_o  (nZRAM)
  );

endmodule

// File: tb/tb_neo_z80_ctrl.sv
// Directed self-checking bench for neo_z80_ctrl.
module tb_neo_z80_ctrl;

  localparam int unsigned MA_W   = 22;
  localparam int unsigned BANK_W = 8;

  logic            clk;
  logic            rst;
  logic            n_sdw;
  logic [7:0]      m68k_data;
  logic [7:0]      sound_reply;
  logic [15:0]     sda;
  logic [7:0]      sdd_in;
  logic [7:0]      sdd_out;
  logic            sdd_oe;
  logic            n_iorq;
  logic            n_mreq;
  logic            n_rd;
  logic            n_wr;
  logic            n_nmi;
  logic [MA_W-1:0] ma;
  logic            n_sdrom;
  logic            n_zram;
  logic            nmi_en;

  int checks = 0;
  int errors = 0;

  neo_z80_ctrl #(
    .MA_W   (MA_W),
    .BANK_W (BANK_W)
  ) dut (
    .CLK_24M     (clk),
    .RESET       (rst),
    .nSDW        (n_sdw),
    .M68K_DATA_U (m68k_data),
    .SOUND_REPLY (sound_reply),
    .SDA         (sda),
    .SDD_IN      (sdd_in),
    .SDD_OUT     (sdd_out),
    .SDD_OE      (sdd_oe),
    .nIORQ       (n_iorq),
    .nMREQ       (n_mreq),
    .nRD         (n_rd),
    .nWR         (n_wr),
    .nZ80NMI     (n_nmi),
    .MA          (ma),
    .nSDROM      (n_sdrom),
    .nZRAM       (n_zram),
    .NMI_EN      (nmi_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_read(input logic [15:0] addr, input int hold);
    sda = addr; n_iorq = 1'b0; n_rd = 1'b0;
    tick(hold);
    n_iorq = 1'b1; n_rd = 1'b1;
    tick(1);
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    sda = addr; sdd_in = data; n_iorq = 1'b0; n_wr = 1'b0;
    tick(hold);
    n_iorq = 1'b1; n_wr = 1'b1;
    tick(1);
  endtask

  task automatic m68k_write(input logic [7:0] data);
    m68k_data = data; n_sdw = 1'b0;
    tick(2);
    n_sdw = 1'b1;
    tick(1);
  endtask

  task automatic fetch(input logic [15:0] addr);
    sda = addr; n_mreq = 1'b0; n_rd = 1'b0;
    #1;
  endtask

  task automatic fetch_end();
    n_mreq = 1'b1; n_rd = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; n_sdw = 1'b1; m68k_data = 8'h00; sda = 16'h0000; sdd_in = 8'h00;
    n_iorq = 1'b1; n_mreq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (sound_reply !== 8'h00) begin errors++; $display("FAIL reset_reply got %h exp 00", sound_reply); end
    checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL reset_nmi got %b exp 1", n_nmi); end
    checks++; if (nmi_en !== 1'b0) begin errors++; $display("FAIL reset_nmi_en got %b exp 0", nmi_en); end
    checks++; if (sdd_out !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h exp 00", sdd_out); end
    checks++; if (sdd_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", sdd_oe); end
    checks++; if (n_sdrom !== 1'b1 || n_zram !== 1'b1) begin
      errors++; $display("FAIL reset_sel got sdrom=%b zram=%b exp 1/1", n_sdrom, n_zram);
    end
  endtask

  task automatic test_linear_map();
    logic [15:0]     addrs [5] = '{16'h1234, 16'h8123, 16'hC456, 16'hE789, 16'hF7FF};
    logic [MA_W-1:0] exps  [5] = '{22'h01234, 22'h08123, 22'h0C456, 22'h0E789, 22'h0F7FF};
    for (int i = 0; i < 5; i++) begin
      fetch(addrs[i]);
      checks++; if (ma !== exps[i] || n_sdrom !== 1'b0 || n_zram !== 1'b1) begin
        errors++;
        $display("FAIL linear_%h got ma=%h sdrom=%b zram=%b exp ma=%h sdrom=0 zram=1",
                 addrs[i], ma, n_sdrom, n_zram, exps[i]);
      end
      fetch_end();
    end
    fetch(16'hF800);
    checks++; if (n_zram !== 1'b0 || n_sdrom !== 1'b1) begin
      errors++; $display("FAIL zram_f800 got zram=%b sdrom=%b exp 0/1", n_zram, n_sdrom);
    end
    fetch_end();
    checks++; if (n_zram !== 1'b1 || n_sdrom !== 1'b1) begin
      errors++; $display("FAIL mreq_idle got zram=%b sdrom=%b exp 1/1", n_zram, n_sdrom);
    end
  endtask

  task automatic test_bank_switch();
    io_read(16'h210A, 2);
    fetch(16'hC010);
    checks++; if (ma !== 22'h042010) begin errors++; $display("FAIL bank2_c010 got %h exp 042010", ma); end
    fetch_end();
    io_read(16'hFF0B, 2);
    fetch(16'h8000);
    checks++; if (ma !== 22'h3FC000) begin errors++; $display("FAIL bank3_8000 got %h exp 3fc000", ma); end
    fetch_end();
    fetch(16'hE789);
    checks++; if (ma !== 22'h00E789) begin errors++; $display("FAIL bank1_kept got %h exp 00e789", ma); end
    fetch_end();
  endtask

  task automatic test_nmi();
    m68k_write(8'h55);
    tick(2);
    checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL nmi_masked got %b exp 1", n_nmi); end
    checks++; if (sdd_out !== 8'h55) begin errors++; $display("FAIL cmd_latch got %h exp 55", sdd_out); end
    sda = 16'h0008; n_iorq = 1'b0; n_wr = 1'b0;
    tick(1);
    checks++; if (nmi_en !== 1'b1 || n_nmi !== 1'b1) begin
      errors++; $display("FAIL nmi_en_lag got en=%b nmi=%b exp 1/1", nmi_en, n_nmi);
    end
    tick(1);
    checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL nmi_assert got %b exp 0", n_nmi); end
    n_iorq = 1'b1; n_wr = 1'b1;
    tick(1);
    sda = 16'h0000; n_iorq = 1'b0; n_rd = 1'b0;
    #1;
    checks++; if (sdd_oe !== 1'b1 || sdd_out !== 8'h55) begin
      errors++; $display("FAIL cmd_read got oe=%b out=%h exp 1/55", sdd_oe, sdd_out);
    end
    tick(2);
    checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL nmi_ack got %b exp 1", n_nmi); end
    n_iorq = 1'b1; n_rd = 1'b1;
    tick(1);
    checks++; if (sdd_oe !== 1'b0) begin errors++; $display("FAIL oe_release got %b exp 0", sdd_oe); end
  endtask

  task automatic test_set_clear_collision();
    m68k_write(8'h66);
    checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL coll_pre got %b exp 0", n_nmi); end
    sda = 16'h0000; n_iorq = 1'b0; n_rd = 1'b0;
    m68k_data = 8'h77; n_sdw = 1'b0;
    tick(3);
    checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL coll_nmi got %b exp 0", n_nmi); end
    checks++; if (sdd_out !== 8'h77) begin errors++; $display("FAIL coll_cmd got %h exp 77", sdd_out); end
    n_iorq = 1'b1; n_rd = 1'b1; n_sdw = 1'b1;
    tick(1);
    io_read(16'h0000, 2);
    tick(1);
    checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL coll_ack got %b exp 1", n_nmi); end
  endtask

  task automatic test_back_to_back();
    sda = 16'h000C; sdd_in = 8'hA5; n_iorq = 1'b0; n_wr = 1'b0;
    tick(1);
    sdd_in = 8'h3C;
    tick(5);
    checks++; if (sound_reply !== 8'hA5) begin errors++; $display("FAIL reply_once got %h exp a5", sound_reply); end
    n_iorq = 1'b1; n_wr = 1'b1;
    tick(1);
    io_write(16'h0018, 8'h00, 2);
    checks++; if (nmi_en !== 1'b0) begin errors++; $display("FAIL nmi_dis got %b exp 0", nmi_en); end
    m68k_write(8'h12);
    tick(2);
    checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL nmi_disabled got %b exp 1", n_nmi); end
    checks++; if (sdd_out !== 8'h12) begin errors++; $display("FAIL cmd_12 got %h exp 12", sdd_out); end
    io_write(16'h0000, 8'hFF, 2);
    checks++; if (sdd_out !== 8'h00) begin errors++; $display("FAIL cmd_clear got %h exp 00", sdd_out); end
    io_write(16'h0004, 8'hEE, 2);
    checks++; if (sound_reply !== 8'hA5) begin errors++; $display("FAIL ym_port got %h exp a5", sound_reply); end
  endtask

  task automatic test_int_ack();
    sda = 16'h000C; sdd_in = 8'h99; n_iorq = 1'b0; n_rd = 1'b1; n_wr = 1'b1;
    tick(2);
    checks++; if (sound_reply !== 8'hA5) begin errors++; $display("FAIL intack_idle got %h exp a5", sound_reply); end
    n_wr = 1'b0;
    tick(1);
    checks++; if (sound_reply !== 8'h99) begin errors++; $display("FAIL intack_then_wr got %h exp 99", sound_reply); end
    n_iorq = 1'b1; n_wr = 1'b1;
    tick(1);
  endtask

  task automatic test_reset_mid();
    logic [15:0]     addrs [4] = '{16'hF000, 16'hE000, 16'hC000, 16'h8000};
    logic [MA_W-1:0] exps  [4] = '{22'h0F000, 22'h0E000, 22'h0C000, 22'h08000};
    io_read(16'h4408, 2);
    fetch(16'hF000);
    checks++; if (ma !== 22'h022000) begin errors++; $display("FAIL bank0_44 got %h exp 022000", ma); end
    fetch_end();
    io_write(16'h0008, 8'h00, 2);
    m68k_write(8'h31);
    tick(1);
    checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL pre_reset_nmi got %b exp 0", n_nmi); end
    sda = 16'h1208; n_iorq = 1'b0; n_rd = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    n_iorq = 1'b1; n_rd = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      fetch(addrs[i]);
      checks++; if (ma !== exps[i]) begin
        errors++; $display("FAIL rst_bank_%h got %h exp %h", addrs[i], ma, exps[i]);
      end
      fetch_end();
    end
    checks++; if (sound_reply !== 8'h00 || n_nmi !== 1'b1 || nmi_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_state got reply=%h nmi=%b en=%b exp 00/1/0", sound_reply, n_nmi, nmi_en);
    end
    // Strobe held across reset must act once more after reset releases.
    sda = 16'h3309; n_iorq = 1'b0; n_rd = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    n_iorq = 1'b1; n_rd = 1'b1;
    tick(1);
    fetch(16'hE000);
    checks++; if (ma !== 22'h033000) begin errors++; $display("FAIL held_strobe got %h exp 033000", ma); end
    fetch_end();
    io_write(16'h000C, 8'h5A, 2);
    checks++; if (sound_reply !== 8'h5A) begin errors++; $display("FAIL post_rst_io got %h exp 5a", sound_reply); end
  endtask

  initial begin
    test_reset();
    test_linear_map();
    test_bank_switch();
    test_nmi();
    test_set_clear_collision();
    test_back_to_back();
    test_int_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
